// File: rtl/gol_frame_capture.sv
// gol_frame_capture: captures one SIDE x SIDE generation streamed serially by
// a life engine during its OUTPUT phase, then commits it to a readable frame
// with population, generation, extinction and overrun status.
// Optional feature macro: GOL_STILL_DETECT_EN (adds previous-frame compare for
// still-life detection; when undefined, o_still_life is tied low).
module gol_frame_capture #(
  parameter int SIDE = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      i_gol_state,
  input  logic            i_gol_bit,
  input  logic [2:0]      i_row_sel,
  output logic [SIDE-1:0] o_row_data,
  output logic            o_frame_valid,
  input  logic            i_frame_ack,
  output logic            o_overrun,
  output logic [7:0]      o_gen_count,
  output logic [5:0]      o_pop_count,
  output logic            o_extinct,
  output logic            o_still_life
);

  localparam int         N    = SIDE * SIDE;
  localparam logic [5:0] LAST = 6'(N - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, COMMIT} state_t;

  state_t       r_state, w_next;
  logic         w_out_phase;
  logic         w_take, w_start, w_commit;
  logic [5:0]   w_slot;
  logic         r_armed;
  logic [5:0]   r_idx;
  logic [5:0]   r_shadow_pop;
  logic [N-1:0] r_shadow;
  logic [N-1:0] r_frame;
  logic [7:0]   w_gen_inc;

  assign w_out_phase = (i_gol_state == 2'b10);
  // Sample 0 is taken in the IDLE cycle that starts the capture.
  assign w_slot      = w_start ? 6'd0 : r_idx;
  assign w_gen_inc   = o_gen_count + 8'd1;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state and per-cycle strobes.
  always_comb begin
    w_next   = r_state;
    w_take   = 1'b0;
    w_start  = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_out_phase && r_armed) begin
          w_take  = 1'b1;
          w_start = 1'b1;
          w_next  = CAPTURE;
        end
      end
      CAPTURE: begin
        if (w_out_phase) begin
          w_take = 1'b1;
          if (r_idx == LAST) w_next = COMMIT;
        end else begin
          w_next = IDLE;  // phase ended early: drop the partial frame
        end
      end
      COMMIT: begin
        w_commit = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Re-arm only once the engine leaves OUTPUT, so trailing bits of a
  // completed phase are not mistaken for a new frame.
  always_ff @(posedge clock) begin
    if (reset)                                    r_armed <= 1'b1;
    else if (!w_out_phase)                        r_armed <= 1'b1;
    else if (r_state == CAPTURE && w_next == COMMIT) r_armed <= 1'b0;
  end

  // Shadow frame fill and running population count.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_idx        <= '0;
      r_shadow     <= '0;
      r_shadow_pop <= '0;
    end else if (w_take) begin
      r_shadow[w_slot] <= i_gol_bit;
      r_idx            <= w_slot + 6'd1;
      r_shadow_pop     <= (w_start ? 6'd0 : r_shadow_pop) + {5'd0, i_gol_bit};
    end
  end

  // Committed frame, status and valid/overrun handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_frame       <= '0;
      o_frame_valid <= 1'b0;
      o_overrun     <= 1'b0;
      o_gen_count   <= '0;
      o_pop_count   <= '0;
      o_extinct     <= 1'b0;
    end else if (w_commit) begin
      r_frame       <= r_shadow;
      o_pop_count   <= r_shadow_pop;
      o_gen_count   <= w_gen_inc;
      o_extinct     <= (r_shadow_pop == 6'd0) && (w_gen_inc != 8'd0);
      o_frame_valid <= 1'b1;
      if (o_frame_valid && !i_frame_ack) o_overrun <= 1'b1;
    end else if (i_frame_ack) begin
      o_frame_valid <= 1'b0;
      o_overrun     <= 1'b0;
    end
  end

`ifdef GOL_STILL_DETECT_EN
  logic [N-1:0] r_prev;
  logic         r_still;

  // Previous-frame compare; the first frame after reset never counts.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_prev  <= '0;
      r_still <= 1'b0;
    end else if (w_commit) begin
      r_prev  <= r_shadow;
      r_still <= (r_shadow == r_prev) && (o_gen_count != 8'd0);
    end
  end

  assign o_still_life = r_still;
`else
  assign o_still_life = 1'b0;
`endif

  // Row readout; out-of-range rows read as empty.
  always_comb begin
    o_row_data = '0;
    if (int'(i_row_sel) < SIDE) o_row_data = r_frame[int'(i_row_sel)*SIDE +: SIDE];
  end

endmodule

// File: tb/tb_gol_frame_capture.sv
// Directed bench for gol_frame_capture (default SIDE=6).
module tb_gol_frame_capture;
  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] gol_state;
  logic       gol_bit;
  logic [2:0] row_sel;
  logic [5:0] row_data;
  logic       frame_valid, frame_ack, overrun, extinct, still_life;
  logic [7:0] gen_count;
  logic [5:0] pop_count;

  int nchecks = 0;
  int nerrors = 0;

`ifdef GOL_STILL_DETECT_EN
  localparam logic STILL_ON = 1'b1;
`else
  localparam logic STILL_ON = 1'b0;
`endif

  gol_frame_capture #(.SIDE(6)) dut (
    .clock(clock), .reset(reset), .i_gol_state(gol_state), .i_gol_bit(gol_bit),
    .i_row_sel(row_sel), .o_row_data(row_data), .o_frame_valid(frame_valid),
    .i_frame_ack(frame_ack), .o_overrun(overrun), .o_gen_count(gen_count),
    .o_pop_count(pop_count), .o_extinct(extinct), .o_still_life(still_life)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_samples(input logic [35:0] f, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      gol_state = 2'b10;
      gol_bit   = f[k];
      cyc();
    end
  endtask

  // Full frame followed by one non-OUTPUT cycle (the COMMIT cycle).
  task automatic send_frame(input logic [35:0] f);
    send_samples(f, 36);
    gol_state = 2'b00;
    gol_bit   = 1'b0;
    cyc();
  endtask

  logic [35:0] glider, stripes, block, zero;

  initial begin
    glider  = 36'h0;
    glider[1] = 1'b1; glider[8] = 1'b1; glider[12] = 1'b1; glider[13] = 1'b1; glider[14] = 1'b1;
    stripes = 36'hF0F0F0F0F;
    block   = 36'h0C3;        // cells 0,1,6,7
    zero    = 36'h0;

    reset = 1'b1; gol_state = 2'b00; gol_bit = 1'b0; row_sel = 3'd0; frame_ack = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    chk("rst_valid", frame_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_gen", gen_count, 0);
    chk("rst_pop", pop_count, 0);
    chk("rst_extinct", extinct, 0);
    chk("rst_still", still_life, 0);
    chk("rst_row0", row_data, 0);

    // Glider frame with latency check.
    send_samples(glider, 36);
    chk("lat_valid_early", frame_valid, 0);
    gol_state = 2'b00;
    cyc();
    chk("glider_valid", frame_valid, 1);
    chk("glider_pop", pop_count, 5);
    chk("glider_gen", gen_count, 1);
    chk("glider_extinct", extinct, 0);
    chk("glider_overrun", overrun, 0);
    row_sel = 3'd2; #1 chk("glider_row2", row_data, 6'b000111);
    row_sel = 3'd0; #1 chk("glider_row0", row_data, 6'b000010);
    row_sel = 3'd1; #1 chk("glider_row1", row_data, 6'b000100);
    row_sel = 3'd6; #1 chk("row6_zero", row_data, 0);
    row_sel = 3'd7; #1 chk("row7_zero", row_data, 0);

    frame_ack = 1'b1; cyc(); frame_ack = 1'b0;
    chk("ack_clears_valid", frame_valid, 0);

    // Abort after 20 samples.
    send_samples(36'hFFFFFFFFF, 20);
    gol_state = 2'b01;
    cyc(); cyc(); cyc();
    chk("abort_valid", frame_valid, 0);
    chk("abort_gen", gen_count, 1);
    chk("abort_pop", pop_count, 5);
    row_sel = 3'd2; #1 chk("abort_row2", row_data, 6'b000111);

    send_frame(stripes);
    chk("stripes_valid", frame_valid, 1);
    chk("stripes_pop", pop_count, 20);
    chk("stripes_gen", gen_count, 2);
    row_sel = 3'd0; #1 chk("stripes_row0", row_data, 6'b001111);
    row_sel = 3'd1; #1 chk("stripes_row1", row_data, 6'b111100);
    frame_ack = 1'b1; cyc(); frame_ack = 1'b0;

    // Two empty frames without ack: extinct and overrun.
    send_frame(zero);
    chk("z1_extinct", extinct, 1);
    chk("z1_overrun", overrun, 0);
    chk("z1_gen", gen_count, 3);
    send_frame(zero);
    chk("z2_extinct", extinct, 1);
    chk("z2_overrun", overrun, 1);
    chk("z2_still", still_life, STILL_ON);
    frame_ack = 1'b1; cyc(); frame_ack = 1'b0;
    chk("z_ack_valid", frame_valid, 0);
    chk("z_ack_overrun", overrun, 0);

    // Block twice; second commit coincides with ack.
    send_frame(block);
    chk("b1_still", still_life, 0);
    chk("b1_pop", pop_count, 4);
    chk("b1_extinct", extinct, 0);
    send_samples(block, 36);
    gol_state = 2'b00; frame_ack = 1'b1;
    cyc();
    frame_ack = 1'b0;
    chk("b2_valid", frame_valid, 1);
    chk("b2_overrun", overrun, 0);
    chk("b2_still", still_life, STILL_ON);
    chk("b2_gen", gen_count, 6);
    row_sel = 3'd1; #1 chk("b2_row1", row_data, 6'b000011);

    // Trailing OUTPUT bits after a full frame are ignored.
    frame_ack = 1'b1; cyc(); frame_ack = 1'b0;
    send_samples(glider, 36);
    send_samples(36'hFFFFFFFFF, 10);
    gol_state = 2'b00; cyc();
    chk("trail_gen", gen_count, 7);
    chk("trail_pop", pop_count, 5);

    // Reset in the middle of a capture.
    send_samples(stripes, 17);
    reset = 1'b1; gol_state = 2'b10; gol_bit = 1'b1;
    cyc();
    reset = 1'b0; gol_state = 2'b00;
    cyc();
    chk("mid_rst_valid", frame_valid, 0);
    chk("mid_rst_gen", gen_count, 0);
    chk("mid_rst_pop", pop_count, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_extinct", extinct, 0);
    chk("mid_rst_still", still_life, 0);
    for (int r = 0; r < 6; r++) begin
      row_sel = 3'(r); #1 chk("mid_rst_row", row_data, 0);
    end

    // Generation counter wrap.
    for (int f = 0; f < 255; f++) send_frame(zero);
    chk("gen_255", gen_count, 255);
    chk("gen_255_extinct", extinct, 1);
    send_frame(zero);
    chk("gen_wrap", gen_count, 0);
    chk("gen_wrap_extinct", extinct, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule

// File: doc/gol_frame_capture.md
GOL_FRAME_CAPTURE -- requirements
Module: gol_frame_capture

Interface
REQ-001 Parameter: SIDE, default 6, grid side length; frame holds SIDE*SIDE cells (36 at default).
REQ-002 clock  input  1  clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 gol_state  input  2  life-engine phase: 00 INPUT, 01 UPDATE, 10 OUTPUT, 11 treated as INPUT.
REQ-005 gol_bit  input  1  serial cell stream from the life engine, valid while gol_state==10.
REQ-006 row_sel  input  3  row index for frame readout.
REQ-007 row_data  output  SIDE  cells of the committed frame row row_sel; bit j = column j.
REQ-008 frame_valid  output  1  committed frame available, held until acknowledged.
REQ-009 frame_ack  input  1  consumer acknowledge for frame_valid.
REQ-010 overrun  output  1  a frame was committed while frame_valid was still pending.
REQ-011 gen_count  output  8  number of frames committed since reset.
REQ-012 pop_count  output  6  live-cell count of the committed frame.
REQ-013 extinct  output  1  committed frame has pop_count==0 and gen_count!=0.
REQ-014 still_life  output  1  committed frame is identical to the previously committed frame.

Function
REQ-015 FSM states: IDLE, CAPTURE, COMMIT.
REQ-016 IDLE->CAPTURE on the first cycle with gol_state==10; that cycle's gol_bit is sample 0.
REQ-017 CAPTURE: one sample per cycle while gol_state==10; a 6-bit sample index increments per sample.
REQ-018 Sample k is stored at row k/SIDE, column k%SIDE (row-major, first bit = row 0 col 0).
REQ-019 The shadow pop counter increments by 1 for each sample equal to 1 and is cleared on entry to CAPTURE.
REQ-020 CAPTURE->COMMIT in the cycle after sample SIDE*SIDE-1 is taken; further OUTPUT-phase bits are ignored until gol_state leaves 10.
REQ-021 CAPTURE->IDLE (abort) if gol_state!=10 before all samples are taken; the committed frame and all outputs stay unchanged.
REQ-022 COMMIT, one cycle: copy the shadow frame to the committed frame, load pop_count, increment gen_count (wraps 255->0), and set frame_valid, all taken in that cycle's edge; next state is IDLE.
REQ-023 After COMMIT, IDLE re-arms only after at least one cycle with gol_state!=10.
REQ-024 Latency: frame_valid is high the cycle after COMMIT, i.e. SIDE*SIDE+1 cycles after sample 0.
REQ-025 frame_valid clears on the edge where frame_ack==1; a simultaneous COMMIT and frame_ack leaves frame_valid=1 and does not set overrun.
REQ-026 A COMMIT while frame_valid==1 and frame_ack==0 overwrites the committed frame and sets overrun.
REQ-027 overrun stays set until an edge with frame_ack==1 and no COMMIT.
REQ-028 row_data is combinational from the committed frame; row_sel>=SIDE yields all zeros.
REQ-029 extinct and still_life are registered at COMMIT and held until the next COMMIT.

Reset
REQ-030 Reset forces IDLE, a zero sample index, a zero shadow frame, and a zero committed frame.
REQ-031 Reset forces row_data=0, frame_valid=0, overrun=0, gen_count=0, pop_count=0, extinct=0, still_life=0.
REQ-032 Reset takes priority over every other event, including mid-capture and in COMMIT.

Configuration
REQ-033 Macro GOL_STILL_DETECT_EN defined: a previous-frame register is kept, loaded at each COMMIT, and still_life = (new frame == previous frame) && gen_count>=1 before the increment.
REQ-034 Macro GOL_STILL_DETECT_EN undefined: no previous-frame storage is built and still_life is tied to 0; all other behaviour is identical.

Verification
REQ-035 Reset, then 36 OUTPUT cycles carrying a glider pattern (cells 1,8,12,13,14) -> frame_valid=1 at cycle 37, pop_count=5, gen_count=1, row_data(row_sel=2)=6'b000111.
REQ-036 OUTPUT drops to 01 after 20 samples -> no frame_valid, gen_count unchanged, next full frame captures correctly.
REQ-037 Two all-zero frames, no ack between them -> extinct=1, overrun=1; frame_ack -> frame_valid=0 and overrun=0 next cycle.
REQ-038 With GOL_STILL_DETECT_EN, two identical 2x2-block frames -> still_life=0 after frame 1 and 1 after frame 2; without the macro -> still_life=0 throughout.
REQ-039 Reset asserted at sample 17 -> all outputs zero; 256 committed frames -> gen_count wraps to 0; row_sel=7 -> row_data=0.
